// File: rtl/eth_frame_packer.sv
// Frame packer: arbitrates N_CH payload streams, prefixes a 16-byte Ethernet/sync
// header, forwards Packet_Size beats from the granted channel and zero-pads short frames.
module eth_frame_packer #(
    parameter int DATA_W          = 64,
    parameter int N_CH            = 2,
    parameter int SIZE_W          = 14,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [47:0]            Destination_Address,
    input  logic [47:0]            Source_Address,
    input  logic [15:0]            Link_Type,
    input  logic [15:0]            SyncWord,
    input  logic [SIZE_W-1:0]      Packet_Size,
    input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]        s_axis_tvalid,
    output logic [N_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic [DATA_W/8-1:0]    m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic [31:0]            frame_count
);

    localparam int HB        = 128 / DATA_W;
    localparam int BB        = DATA_W / 8;
    localparam int MIN_BEATS = (MIN_FRAME_BYTES + BB - 1) / BB;
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W     = SIZE_W + 1;

    localparam logic [CNT_W-1:0] HB_C     = CNT_W'(HB);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HB - 1);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_BEATS);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_BEATS - 1);

    // state   | meaning
    // IDLE    | waiting for a valid channel and a non-zero Packet_Size
    // HEADER  | emitting the HB header beats
    // PAYLOAD | forwarding beats from the granted channel, then awaiting tlast accept
    // PAD     | emitting zero beats up to MIN_BEATS, then awaiting tlast accept
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  beat_q, beat_n;
    logic [CH_W-1:0]   rr_q, grant_q, grant_c, rr_next;
    logic [47:0]       dest_q, src_q;
    logic [15:0]       et_q, sync_q;
    logic [SIZE_W-1:0] size_q;
    logic [CNT_W-1:0]  pay_end;
    logic [127:0]      hdr;
    logic [DATA_W-1:0] hdr_beat, emit_data;
    logic              load, emit, emit_last, start, found, tlast_acc;
    logic [N_CH-1:0]   ready_c;
    int                idx;

    assign load      = !m_axis_tvalid || m_axis_tready;
    assign tlast_acc = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign pay_end   = HB_C + {1'b0, size_q};
    assign busy      = (state_q != IDLE);
    assign m_axis_tkeep  = {BB{m_axis_tvalid}};
    assign s_axis_tready = ready_c;

    always_comb begin
        grant_c = rr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_q) + i) % N_CH;
            if (!found && s_axis_tvalid[idx]) begin
                found   = 1'b1;
                grant_c = CH_W'(idx);
            end
        end
        rr_next = (grant_c == CH_W'(N_CH - 1)) ? '0 : grant_c + 1'b1;
    end

    // Byte n of the header sits in hdr[8n +: 8] so beat k is simply hdr[k*DATA_W +: DATA_W].
    always_comb begin
        hdr = '0;
        for (int i = 0; i < 6; i++) begin
            hdr[8*i +: 8]      = dest_q[8*(5-i) +: 8];
            hdr[48+8*i +: 8]   = src_q[8*(5-i) +: 8];
        end
        hdr[103:96]  = et_q[15:8];
        hdr[111:104] = et_q[7:0];
        hdr[119:112] = sync_q[15:8];
        hdr[127:120] = sync_q[7:0];
        hdr_beat = '0;
        for (int b = 0; b < HB; b++) begin
            if (beat_q == CNT_W'(b)) hdr_beat = hdr[b*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_n   = state_q;
        beat_n    = beat_q;
        emit      = 1'b0;
        emit_data = '0;
        emit_last = 1'b0;
        start     = 1'b0;
        ready_c   = '0;
        case (state_q)
            IDLE: begin
                if (Packet_Size != '0 && found) begin
                    start   = 1'b1;
                    beat_n  = '0;
                    state_n = HEADER;
                end
            end
            HEADER: begin
                if (load) begin
                    emit      = 1'b1;
                    emit_data = hdr_beat;
                    beat_n    = beat_q + 1'b1;
                    if (beat_q == HB_LAST) state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (beat_q < pay_end) begin
                    ready_c[grant_q] = load;
                    if (load && s_axis_tvalid[grant_q]) begin
                        emit      = 1'b1;
                        emit_data = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
                        beat_n    = beat_q + 1'b1;
                        if (beat_q == pay_end - 1'b1) begin
                            if (pay_end < MIN_C) state_n = PAD;
                            else                 emit_last = 1'b1;
                        end
                    end
                end else if (tlast_acc) begin
                    state_n = IDLE;
                end
            end
            PAD: begin
                if (beat_q < MIN_C) begin
                    if (load) begin
                        emit      = 1'b1;
                        beat_n    = beat_q + 1'b1;
                        emit_last = (beat_q == MIN_LAST);
                    end
                end else if (tlast_acc) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            rr_q          <= '0;
            grant_q       <= '0;
            dest_q        <= '0;
            src_q         <= '0;
            et_q          <= '0;
            sync_q        <= '0;
            size_q        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= '0;
        end else begin
            state_q <= state_n;
            beat_q  <= beat_n;
            if (start) begin
                grant_q <= grant_c;
                rr_q    <= rr_next;
                dest_q  <= Destination_Address;
                src_q   <= Source_Address;
                et_q    <= Link_Type + 16'(grant_c);
                sync_q  <= SyncWord;
                size_q  <= Packet_Size;
            end
            if (load) begin
                m_axis_tvalid <= emit;
                m_axis_tdata  <= emit_data;
                m_axis_tlast  <= emit_last;
            end
            if (tlast_acc) frame_count <= frame_count + 32'd1;
        end
    end

endmodule
